// File: rtl/tlc_pkg.sv
// Shared encodings for the traffic-light controller: farm-light colours and
// the farm-road sensor conditioner's state machine.
package tlc_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10
  } light_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    PENDING = 2'd2,
    SERVING = 2'd3
  } cond_state_e;

  localparam logic [7:0] SERVED_MAX = 8'hFF;

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer for a single asynchronous input. The flops carry no
// reset, so the output is valid two clock edges after power-up.
module synchronizer (
  output logic out,
  input  logic in,
  input  logic clk
);

  logic meta_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from before the edge, giving a true two-stage pipeline.
  always_ff @(posedge clk) begin
    meta_q <= in;
    out    <= meta_q;
  end

endmodule

// File: rtl/farm_sensor_conditioner.sv
// Debounces the farm-road vehicle detector into a latched request for the
// light FSM and counts requests that have been served with a green light.
module farm_sensor_conditioner
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10_000_000,
  parameter int CNT_W           = 24
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       sensorRaw,
  input  logic [1:0] farmSignal,
  output logic       farmSensor,
  output logic       requestPending,
  output logic [1:0] condState,
  output logic [7:0] servedCount
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic        sensor_sync;
  cond_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]  served_q, served_d;
  logic        farm_sensor_q, farm_sensor_d;
  logic        pending_q, pending_d;

  synchronizer u_sync (
    .out (sensor_sync),
    .in  (sensorRaw),
    .clk (Clk)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    served_d = served_q;
    unique case (state_q)
      IDLE: begin
        if (sensor_sync) begin
          state_d = QUALIFY;
          cnt_d   = '0;
        end
      end
      QUALIFY: begin
        // Any dropout restarts qualification from scratch.
        if (!sensor_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PENDING;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PENDING: begin
        if (farmSignal == GREEN) state_d = SERVING;
      end
      SERVING: begin
        if (farmSignal != GREEN) begin
          state_d = IDLE;
          if (served_q != SERVED_MAX) served_d = served_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    farm_sensor_d = (state_d == PENDING) || ((state_d == SERVING) && sensor_sync);
    pending_d     = (state_d == PENDING);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      served_q      <= '0;
      farm_sensor_q <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      served_q      <= served_d;
      farm_sensor_q <= farm_sensor_d;
      pending_q     <= pending_d;
    end
  end

  assign farmSensor     = farm_sensor_q;
  assign requestPending = pending_q;
  assign condState      = state_q;
  assign servedCount    = served_q;

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// Bench for farm_sensor_conditioner: two instances (debounce 4 and 1) share
// stimulus and are compared every cycle against a request-level model.
module tb_farm_sensor_conditioner;
  import tlc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       raw = 1'b0;
  logic [1:0] farm = 2'b10;

  logic       fs [2];
  logic       rp [2];
  logic [1:0] cs [2];
  logic [7:0] sc [2];

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  farm_sensor_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut0 (
    .Clk(clk), .Rst(rst), .sensorRaw(raw), .farmSignal(farm),
    .farmSensor(fs[0]), .requestPending(rp[0]), .condState(cs[0]), .servedCount(sc[0])
  );

  farm_sensor_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(1)) dut1 (
    .Clk(clk), .Rst(rst), .sensorRaw(raw), .farmSignal(farm),
    .farmSensor(fs[1]), .requestPending(rp[1]), .condState(cs[1]), .servedCount(sc[1])
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  // Model: the detector seen two edges late; a run length of consecutive
  // highs while qualifying (-1 = not qualifying), a latched request flag, a
  // serving flag and a saturating served tally.
  int dc     [2] = '{4, 1};
  int run    [2] = '{-1, -1};
  bit lat    [2] = '{0, 0};
  bit srv    [2] = '{0, 0};
  int served [2] = '{0, 0};
  bit mfs    [2] = '{0, 0};
  bit s1 = 1'b0, s2 = 1'b0, m_sync;

  always @(posedge clk) begin
    m_sync = s2;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        run[i] = -1; lat[i] = 0; srv[i] = 0; served[i] = 0;
      end else if (srv[i]) begin
        if (farm != GREEN) begin
          srv[i] = 0;
          if (served[i] < 255) served[i]++;
        end
      end else if (lat[i]) begin
        if (farm == GREEN) begin lat[i] = 0; srv[i] = 1; end
      end else if (run[i] >= 0) begin
        if (!m_sync) run[i] = -1;
        else if (run[i] == dc[i] - 1) begin run[i] = -1; lat[i] = 1; end
        else run[i]++;
      end else if (m_sync) begin
        run[i] = 0;
      end
      mfs[i] = !rst && (lat[i] || (srv[i] && m_sync));
    end
    s2 = s1;
    s1 = raw;
  end

  function automatic logic [7:0] m_cond(int i);
    if (srv[i]) return 8'd3;
    if (lat[i]) return 8'd2;
    if (run[i] >= 0) return 8'd1;
    return 8'd0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("model_fs%0d", i), 8'(fs[i]), 8'(mfs[i]));
        check($sformatf("model_rp%0d", i), 8'(rp[i]), 8'(lat[i]));
        check($sformatf("model_cs%0d", i), 8'(cs[i]), m_cond(i));
        check($sformatf("model_sc%0d", i), sc[i], 8'(served[i]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_cs%0d", tag, i), 8'(cs[i]), 8'd0);
      check($sformatf("%s_fs%0d", tag, i), 8'(fs[i]), 8'd0);
      check($sformatf("%s_rp%0d", tag, i), 8'(rp[i]), 8'd0);
      check($sformatf("%s_sc%0d", tag, i), sc[i], 8'd0);
    end
  endtask

  initial begin
    logic [7:0] glitch_cs [7] = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2};

    // Reset with the detector low; the synchronizer flushes meanwhile.
    tick(3);
    rst = 1'b0;
    chk_en = 1'b1;
    check_zero("reset");

    // Latency: detector high from edge 0, request after edge 6 (dc=4),
    // after edge 3 for dc=1.
    tick(1);
    raw = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("lat_fs0_e%0d", k), 8'(fs[0]), (k >= 6) ? 8'd1 : 8'd0);
      check($sformatf("lat_cs0_e%0d", k), 8'(cs[0]),
            (k < 2) ? 8'd0 : (k < 6) ? 8'd1 : 8'd2);
      check($sformatf("lat_cs1_e%0d", k), 8'(cs[1]),
            (k < 2) ? 8'd0 : (k == 2) ? 8'd1 : 8'd2);
    end
    check("lat_rp0", 8'(rp[0]), 8'd1);

    // Detector dropout while pending does not cancel the request.
    tick(1);
    raw = 1'b0;
    tick(100);
    @(negedge clk);
    check("hold_fs0", 8'(fs[0]), 8'd1);
    check("hold_cs0", 8'(cs[0]), 8'd2);

    // Green for 10 cycles then yellow: serve and count.
    tick(1);
    farm = 2'b00;
    tick(9);
    @(negedge clk);
    check("serve_cs0", 8'(cs[0]), 8'd3);
    tick(1);
    farm = 2'b01;
    tick(1);
    @(negedge clk);
    check("served_cs0", 8'(cs[0]), 8'd0);
    check("served_sc0", sc[0], 8'd1);
    check("served_fs0", 8'(fs[0]), 8'd0);

    // Single-cycle glitch during qualification restarts the count.
    tick(1);
    farm = 2'b10;
    raw = 1'b1;
    tick(3);
    raw = 1'b0;
    tick(1);
    raw = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("glitch_cs0_%0d", k), 8'(cs[0]), glitch_cs[k]);
      check($sformatf("glitch_fs0_%0d", k), 8'(fs[0]), (k == 6) ? 8'd1 : 8'd0);
    end
    tick(1);
    raw = 1'b0;
    farm = 2'b00;
    tick(3);
    farm = 2'b10;
    tick(3);
    @(negedge clk);
    check("glitch_sc0", sc[0], 8'd2);
    check("glitch_sc1", sc[1], 8'd2);

    // Reset mid-qualify, then mid-serve.
    tick(1);
    raw = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    check_zero("rst_qual");
    rst = 1'b0;
    tick(8);
    farm = 2'b00;
    tick(2);
    rst = 1'b1;
    tick(1);
    check_zero("rst_serve");
    rst = 1'b0;
    farm = 2'b10;
    raw = 1'b0;
    tick(4);

    // Saturation of the served counter.
    for (int n = 0; n < 260; n++) begin
      raw = 1'b1;
      tick(8);
      raw = 1'b0;
      farm = 2'b00;
      tick(2);
      farm = 2'b10;
      tick(3);
    end
    @(negedge clk);
    check("sat_sc0", sc[0], 8'd255);
    check("sat_sc1", sc[1], 8'd255);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/farm_sensor_conditioner.md
FARM_SENSOR_CONDITIONER -- requirements
Module: farm_sensor_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 10_000_000 (100 ms at 100 MHz): consecutive synchronized-high cycles required to qualify a vehicle.
REQ-002 SHALL have parameter CNT_W, default 24: width of the debounce counter; SHALL satisfy 2**CNT_W >= DEBOUNCE_CYCLES.
REQ-003 SHALL have port Clk, input, 1: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port sensorRaw, input, 1: asynchronous raw farm-road vehicle detector.
REQ-006 SHALL have port farmSignal, input, 2: current farm light, fed back from the light FSM (encoding per REQ-026).
REQ-007 SHALL have port farmSensor, output, 1: qualified vehicle request to the light FSM.
REQ-008 SHALL have port requestPending, output, 1: high while a qualified request awaits green.
REQ-009 SHALL have port condState, output, 2: FSM state for debug header.
REQ-010 SHALL have port servedCount, output, 8: saturating count of requests served.

Function
REQ-011 sensorRaw SHALL pass through a 2-flop synchronizer; only its output (sensorSync) SHALL be used internally.
REQ-012 FSM states SHALL be IDLE=0, QUALIFY=1, PENDING=2, SERVING=3, driven on condState.
REQ-013 IDLE: sensorSync=1 -> QUALIFY with counter cleared to 0; otherwise stay.
REQ-014 QUALIFY: sensorSync=0 -> IDLE and counter cleared; counter == DEBOUNCE_CYCLES-1 -> PENDING; else counter increments by 1.
REQ-015 PENDING: farmSignal==GREEN -> SERVING; otherwise stay, regardless of sensorSync (request latched; vehicle dropout does not cancel).
REQ-016 SERVING: farmSignal!=GREEN -> IDLE and servedCount increments (saturating at 255); else stay.
REQ-017 farmSensor SHALL be registered: 1 in PENDING; equal to sensorSync in SERVING; 0 in IDLE and QUALIFY.
REQ-018 requestPending SHALL be 1 exactly when state is PENDING.
REQ-019 Latency: with sensorRaw held high, farmSensor SHALL rise DEBOUNCE_CYCLES+2 rising edges after the edge first sampling sensorRaw high.
REQ-020 DEBOUNCE_CYCLES=1: QUALIFY SHALL last exactly one cycle before PENDING.
REQ-021 farmSignal already GREEN on entry to PENDING: SHALL spend exactly one cycle in PENDING, then SERVING.
REQ-022 A single-cycle low on sensorSync anywhere in QUALIFY SHALL abort to IDLE; no partial credit retained.
REQ-023 Counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL not wrap.

Reset
REQ-024 Rst=1 at a rising edge SHALL force state IDLE, counter 0, farmSensor 0, requestPending 0, servedCount 0, overriding all transitions, including mid-QUALIFY and mid-SERVING.
REQ-025 Synchronizer flops SHALL NOT be reset; sensorSync becomes valid two edges after power-up.

Structure
REQ-026 Shared package tlc_pkg SHALL hold light encodings GREEN=2'b00, YELLOW=2'b01, RED=2'b10 and the conditioner state encodings; the light FSM uses the same package.
REQ-027 Synchronization SHALL reuse the existing synchronizer sub-module (ports out, in, clk); no other sub-modules.
REQ-028 Instantiated upstream of the light FSM: farmSensor drives its farmSensor input; farmSignal is looped back from its output.

Verification
REQ-029 DEBOUNCE_CYCLES=4, farmSignal=RED, sensorRaw high from edge 0 -> farmSensor and requestPending rise after edge 6; condState=2.
REQ-030 DEBOUNCE_CYCLES=4, sensorRaw high 3 cycles, low 1, high again -> no PENDING until 4 consecutive sync-high cycles; farmSensor 0 throughout the glitch.
REQ-031 In PENDING, sensorRaw drops low for 100 cycles with farmSignal=RED -> farmSensor stays 1.
REQ-032 PENDING, farmSignal->GREEN then YELLOW after 10 cycles -> SERVING for 10 cycles, then IDLE, servedCount 0->1, farmSensor 0.
REQ-033 Rst pulsed one cycle during QUALIFY and again during SERVING -> next cycle condState=0, all outputs 0, servedCount 0.
REQ-034 Drive 260 complete serve cycles -> servedCount saturates at 255.
